// File: rtl/usb_blaster_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usb_blaster_pkg
// Description : Shared FSM states, opcode bit positions and widths for the
//               USB-Blaster JTAG engine.
// Revision    : 1.0
// ============================================================================
package usb_blaster_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        BB_HOLD    = 3'd1,
        SHIFT_WAIT = 3'd2,
        SHIFT_LO   = 3'd3,
        SHIFT_HI   = 3'd4,
        RESP       = 3'd5
    } state_t;

    // Bit positions inside a command byte
    localparam int unsigned c_bit_tck   = 0;
    localparam int unsigned c_bit_tms   = 1;
    localparam int unsigned c_bit_tdi   = 4;
    localparam int unsigned c_bit_read  = 6;
    localparam int unsigned c_bit_shift = 7;

    localparam int unsigned COUNT_W = 6;

endpackage
`default_nettype wire

// File: rtl/usb_blaster_tck_timer.sv
`default_nettype none
// ============================================================================
// Module      : usb_blaster_tck_timer
// Description : TCK half-period down-counter; load starts a TCK_DIV-cycle
//               phase, expire flags its final cycle.
// Revision    : 1.0
// ============================================================================
module usb_blaster_tck_timer #(
    parameter int unsigned TCK_DIV = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_load,
    output logic o_expire
);

    logic [7:0] r_count;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_count <= 8'd0;
        end else if (i_load) begin
            r_count <= 8'(TCK_DIV - 1);
        end else if (r_count != 8'd0) begin
            r_count <= r_count - 8'd1;
        end
    end

    assign o_expire = (r_count == 8'd0);

endmodule
`default_nettype wire

// File: rtl/usb_blaster_jtag_engine.sv
`default_nettype none
// ============================================================================
// Module      : usb_blaster_jtag_engine
// Description : USB-Blaster byte protocol decoder driving TCK/TMS/TDI and
//               returning sampled TDO as response bytes.
// Revision    : 1.0
// ============================================================================
module usb_blaster_jtag_engine
    import usb_blaster_pkg::*;
#(
    parameter int unsigned TCK_DIV = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       jtag_tck,
    output logic       jtag_tms,
    output logic       jtag_tdi,
    input  logic       jtag_tdo,
    output logic       busy
);

    state_t             r_state;
    logic               r_tck;
    logic               r_tms;
    logic               r_tdi;
    logic [7:0]         r_tx_data;
    logic               r_tx_valid;
    logic [COUNT_W-1:0] r_count;
    logic               r_read;
    logic [7:0]         r_shift;
    logic [2:0]         r_bit_idx;
    logic               r_tdo_meta;
    logic               r_tdo_sync;

    logic w_accept;
    logic w_expire;
    logic w_load;

    assign rx_ready = reset_n && ((r_state == IDLE) || (r_state == SHIFT_WAIT));
    assign w_accept = rx_valid && rx_ready;

    // Every half-period starts on an accepted byte or on the end of the previous one
    assign w_load = (w_accept && (r_state == IDLE) && !rx_data[c_bit_shift])
                 || (w_accept && (r_state == SHIFT_WAIT))
                 || (w_expire && (r_state == SHIFT_LO))
                 || (w_expire && (r_state == SHIFT_HI) && (r_bit_idx != 3'd7));

    usb_blaster_tck_timer #(
        .TCK_DIV (TCK_DIV)
    ) u_tck_timer (
        .clock    (clock),
        .reset_n  (reset_n),
        .i_load   (w_load),
        .o_expire (w_expire)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_tck      <= 1'b0;
            r_tms      <= 1'b1;
            r_tdi      <= 1'b0;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_count    <= '0;
            r_read     <= 1'b0;
            r_shift    <= 8'h00;
            r_bit_idx  <= 3'd0;
            r_tdo_meta <= 1'b0;
            r_tdo_sync <= 1'b0;
        end else begin
            r_tdo_meta <= jtag_tdo;
            r_tdo_sync <= r_tdo_meta;

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_read <= rx_data[c_bit_read];
                        if (rx_data[c_bit_shift]) begin
                            r_count <= rx_data[COUNT_W-1:0];
                            r_state <= (rx_data[COUNT_W-1:0] == '0) ? IDLE : SHIFT_WAIT;
                        end else begin
                            r_tck   <= rx_data[c_bit_tck];
                            r_tms   <= rx_data[c_bit_tms];
                            r_tdi   <= rx_data[c_bit_tdi];
                            r_state <= BB_HOLD;
                        end
                    end
                end

                BB_HOLD: begin
                    if (w_expire) begin
                        if (r_read) begin
                            r_tx_data  <= {7'b0, r_tdo_sync};
                            r_tx_valid <= 1'b1;
                            r_state    <= RESP;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end

                SHIFT_WAIT: begin
                    if (w_accept) begin
                        r_shift   <= rx_data;
                        r_bit_idx <= 3'd0;
                        r_tck     <= 1'b0;
                        r_tdi     <= rx_data[0];
                        r_state   <= SHIFT_LO;
                    end
                end

                SHIFT_LO: begin
                    if (w_expire) begin
                        r_shift <= {r_tdo_sync, r_shift[7:1]};
                        r_tck   <= 1'b1;
                        r_state <= SHIFT_HI;
                    end
                end

                SHIFT_HI: begin
                    if (w_expire) begin
                        r_tck <= 1'b0;
                        if (r_bit_idx == 3'd7) begin
                            r_count <= r_count - COUNT_W'(1);
                            if (r_read) begin
                                r_tx_data  <= r_shift;
                                r_tx_valid <= 1'b1;
                                r_state    <= RESP;
                            end else begin
                                r_state <= (r_count == COUNT_W'(1)) ? IDLE : SHIFT_WAIT;
                            end
                        end else begin
                            // Shift register already moved, so bit 0 is the next TDI bit
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tdi     <= r_shift[0];
                            r_state   <= SHIFT_LO;
                        end
                    end
                end

                RESP: begin
                    if (tx_ready) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= (r_count == '0) ? IDLE : SHIFT_WAIT;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign jtag_tck = r_tck;
    assign jtag_tms = r_tms;
    assign jtag_tdi = r_tdi;
    assign busy     = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_usb_blaster_jtag_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_blaster_jtag_engine
// Description : Self-checking bench for usb_blaster_jtag_engine with a
//               per-cycle behavioural plan model and directed scenarios.
// Revision    : 1.0
// ============================================================================
module tb_usb_blaster_jtag_engine;

    localparam int TCK_DIV = 4;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       jtag_tck, jtag_tms, jtag_tdi;
    logic       jtag_tdo;
    logic       busy;

    logic       dir_ready = 1'b1;
    logic       rnd_ready = 1'b1;
    logic       rnd_mode  = 1'b0;
    logic [1:0] tdo_sel   = 2'd0;
    logic       tdo_dir   = 1'b0;
    logic       tdo_rnd   = 1'b0;

    assign tx_ready = rnd_mode ? rnd_ready : dir_ready;
    assign jtag_tdo = (tdo_sel == 2'd1) ? jtag_tdi : ((tdo_sel == 2'd2) ? tdo_rnd : tdo_dir);

    usb_blaster_jtag_engine #(.TCK_DIV(TCK_DIV)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .jtag_tck (jtag_tck),
        .jtag_tms (jtag_tms),
        .jtag_tdi (jtag_tdi),
        .jtag_tdo (jtag_tdo),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    always @(posedge clock) begin
        #1;
        tdo_rnd   = 1'($urandom_range(0, 1));
        rnd_ready = ($urandom_range(0, 3) != 0);
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model: queue of expected cycles ----------------
    typedef struct {
        bit tck;
        bit tms;
        bit tdi;
        bit cap;      // TDO captured (value seen on the pin two cycles earlier)
        bit resp;     // response offered, held until tx_ready
        bit bitresp;  // response is a single TDO bit rather than a byte
    } step_t;

    step_t      plan[$];
    bit         a_tck = 0, a_tms = 1, a_tdi = 0;
    int         m_rem = 0;
    bit         m_read = 0;
    logic [7:0] m_cap = 8'h00;
    bit         h1 = 0, h2 = 0;
    bit         prev_rst = 0;

    task automatic push_step(input bit tck, input bit tms, input bit tdi,
                             input bit cap, input bit resp, input bit bitresp);
        step_t s;
        s.tck = tck; s.tms = tms; s.tdi = tdi;
        s.cap = cap; s.resp = resp; s.bitresp = bitresp;
        plan.push_back(s);
    endtask

    task automatic model_accept(input logic [7:0] b);
        if (m_rem > 0) begin
            m_rem--;
            for (int i = 0; i < 8; i++) begin
                for (int j = 0; j < TCK_DIV; j++) push_step(0, a_tms, b[i], j == TCK_DIV - 1, 0, 0);
                for (int j = 0; j < TCK_DIV; j++) push_step(1, a_tms, b[i], 0, 0, 0);
            end
            a_tck = 0;
            a_tdi = b[7];
            if (m_read) push_step(0, a_tms, a_tdi, 0, 1, 0);
        end else if (b[7]) begin
            m_rem  = int'(b[5:0]);
            m_read = b[6];
        end else begin
            for (int j = 0; j < TCK_DIV; j++) push_step(b[0], b[1], b[4], b[6] && (j == TCK_DIV - 1), 0, 0);
            a_tck = b[0]; a_tms = b[1]; a_tdi = b[4];
            if (b[6]) push_step(a_tck, a_tms, a_tdi, 0, 1, 1);
        end
    endtask

    always @(negedge clock) begin
        logic [2:0] e_pins;
        logic       e_rdy, e_busy, e_txv;
        logic [7:0] e_txd;
        if (!reset_n) begin
            check("reset_rx_ready", {7'b0, rx_ready}, 8'h00);
            if (prev_rst) begin
                check("reset_pins", {5'b0, jtag_tck, jtag_tms, jtag_tdi}, 8'h02);
                check("reset_tx_valid", {7'b0, tx_valid}, 8'h00);
                check("reset_busy", {7'b0, busy}, 8'h00);
            end
            plan.delete();
            a_tck = 0; a_tms = 1; a_tdi = 0;
            m_rem = 0; m_read = 0; h1 = 0; h2 = 0;
            prev_rst = 1;
        end else begin
            prev_rst = 0;
            if (plan.size() != 0) begin
                e_pins = {plan[0].tck, plan[0].tms, plan[0].tdi};
                e_rdy  = 0;
                e_busy = 1;
                e_txv  = plan[0].resp;
                e_txd  = plan[0].bitresp ? {7'b0, m_cap[7]} : m_cap;
            end else begin
                e_pins = {a_tck, a_tms, a_tdi};
                e_rdy  = 1;
                e_busy = (m_rem != 0);
                e_txv  = 0;
                e_txd  = 8'h00;
            end
            check("model_pins", {5'b0, jtag_tck, jtag_tms, jtag_tdi}, {5'b0, e_pins});
            check("model_rx_ready", {7'b0, rx_ready}, {7'b0, e_rdy});
            check("model_busy", {7'b0, busy}, {7'b0, e_busy});
            check("model_tx_valid", {7'b0, tx_valid}, {7'b0, e_txv});
            if (e_txv) check("model_tx_data", tx_data, e_txd);

            if (plan.size() != 0) begin
                if (plan[0].cap) m_cap = {h2, m_cap[7:1]};
                if (!plan[0].resp || tx_ready) void'(plan.pop_front());
            end else if (rx_valid) begin
                model_accept(rx_data);
            end
            h2 = h1;
            h1 = jtag_tdo;
        end
    end

    // ---------------- monitors ----------------
    logic [7:0]  resp_log[$];
    int          rise_cnt = 0;
    int          txv_rise = -1;
    logic [15:0] tdi_word = 16'h0000;
    bit          prev_tck = 0, prev_txv = 0;

    always @(negedge clock) begin
        if (tx_valid && !prev_txv) txv_rise = cyc;
        prev_txv = tx_valid;
        if (reset_n && tx_valid && tx_ready) resp_log.push_back(tx_data);
        if (jtag_tck && !prev_tck) begin
            rise_cnt++;
            tdi_word = {jtag_tdi, tdi_word[15:1]};
        end
        prev_tck = jtag_tck;
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [7:0] b, output int t);
        @(posedge clock); #1;
        rx_valid = 1'b1;
        rx_data  = b;
        t = -1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clock);
            if (rx_ready) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) begin
            n_tests++; n_fail++;
            $display("FAIL send_timeout byte %0h: got no accept, expected accept within 3000 cycles", b);
        end
        @(posedge clock); #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_resp(input int n);
        int k;
        for (k = 0; k < 3000; k++) begin
            if (resp_log.size() >= n) break;
            @(negedge clock);
        end
        if (resp_log.size() < n) begin
            n_tests++; n_fail++;
            $display("FAIL resp_timeout: got %0d responses, expected %0d", resp_log.size(), n);
        end
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 3000; k++) begin
            @(negedge clock);
            if (!busy) break;
        end
        check("idle_reached", {7'b0, busy}, 8'h00);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t0, t1, r0, n0, k;
        logic [7:0] b;

        // Reset
        repeat (5) @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        check("post_reset_rx_ready", {7'b0, rx_ready}, 8'h01);
        check("post_reset_pins", {5'b0, jtag_tck, jtag_tms, jtag_tdi}, 8'h02);
        check("post_reset_tx_data", tx_data, 8'h00);
        check("post_reset_tx_valid", {7'b0, tx_valid}, 8'h00);

        // Bit-bang, no read
        n0 = resp_log.size();
        send(8'h13, t0);
        @(negedge clock);
        check("bb_pins_0x13", {5'b0, jtag_tck, jtag_tms, jtag_tdi}, 8'h07);
        send(8'h00, t1);
        check("bb_accept_spacing", 8'(t1 - t0), 8'(TCK_DIV + 1));
        repeat (TCK_DIV + 3) @(negedge clock);
        check("bb_no_response", 8'(resp_log.size() - n0), 8'h00);

        // Bit-bang with read
        tdo_dir = 1'b1;
        send(8'h50, t0);
        @(negedge clock);
        check("bbr_pins_0x50", {5'b0, jtag_tck, jtag_tms, jtag_tdi}, 8'h01);
        wait_resp(n0 + 1);
        check("bbr_tx_latency", 8'(txv_rise - t0), 8'(TCK_DIV + 1));
        if (resp_log.size() > n0) check("bbr_tx_data", resp_log[n0], 8'h01);
        wait_idle();

        // Shift with loopback
        tdo_sel = 2'd1;
        r0 = rise_cnt;
        n0 = resp_log.size();
        send(8'hC2, t0);
        send(8'hA5, t0);
        send(8'h3C, t0);
        wait_resp(n0 + 2);
        wait_idle();
        check("loop_tck_rises", 8'(rise_cnt - r0), 8'd16);
        check("loop_tdi_lo", tdi_word[7:0], 8'hA5);
        check("loop_tdi_hi", tdi_word[15:8], 8'h3C);
        if (resp_log.size() >= n0 + 2) begin
            check("loop_resp0", resp_log[n0], 8'hA5);
            check("loop_resp1", resp_log[n0 + 1], 8'h3C);
        end
        check("loop_tms_kept", {7'b0, jtag_tms}, 8'h00);

        // Backpressure
        @(posedge clock); #1 dir_ready = 1'b0;
        n0 = resp_log.size();
        send(8'hC2, t0);
        send(8'hA5, t0);
        for (k = 0; k < 500 && !tx_valid; k++) @(negedge clock);
        check("bp_tx_valid_seen", {7'b0, tx_valid}, 8'h01);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check("bp_hold_valid", {7'b0, tx_valid}, 8'h01);
            check("bp_hold_data", tx_data, 8'hA5);
            check("bp_hold_tck_ready", {6'b0, jtag_tck, rx_ready}, 8'h00);
        end
        @(posedge clock); #1 dir_ready = 1'b1;
        send(8'h3C, t0);
        for (k = 0; k < 100 && !jtag_tck; k++) @(negedge clock);
        check("bp_resume_rise", 8'(cyc - t0), 8'(TCK_DIV + 1));
        wait_resp(n0 + 2);
        if (resp_log.size() >= n0 + 2) begin
            check("bp_resp0", resp_log[n0], 8'hA5);
            check("bp_resp1", resp_log[n0 + 1], 8'h3C);
        end
        wait_idle();

        // Zero-count header
        r0 = rise_cnt;
        send(8'h80, t0);
        @(negedge clock);
        check("hdr0_ready_busy", {6'b0, rx_ready, busy}, 8'h02);
        repeat (8) @(negedge clock);
        check("hdr0_no_edges", 8'(rise_cnt - r0), 8'h00);

        // Reset during SHIFT_HI
        send(8'h81, t0);
        send(8'hFF, t0);
        for (k = 0; k < 100 && !jtag_tck; k++) @(negedge clock);
        check("rst_mid_reached_hi", {7'b0, jtag_tck}, 8'h01);
        @(posedge clock); #1 reset_n = 1'b0;
        @(posedge clock); #1 reset_n = 1'b1;
        @(negedge clock);
        check("rst_mid_tck_txv", {6'b0, jtag_tck, tx_valid}, 8'h00);
        n0 = resp_log.size();
        send(8'hC1, t0);
        send(8'h96, t0);
        wait_resp(n0 + 1);
        if (resp_log.size() > n0) check("rst_mid_after_resp", resp_log[n0], 8'h96);
        wait_idle();

        // Randomised traffic against the model
        tdo_sel  = 2'd2;
        rnd_mode = 1'b1;
        for (int n = 0; n < 50; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                b = 8'($urandom) & 8'h7F;
                send(b, t0);
            end else begin
                k = $urandom_range(0, 3);
                b = 8'h80 | 8'(k);
                if ($urandom_range(0, 1) == 1) b = b | 8'h40;
                send(b, t0);
                for (int j = 0; j < k; j++) begin
                    b = 8'($urandom);
                    send(b, t0);
                end
            end
            repeat ($urandom_range(0, 3)) @(posedge clock);
        end
        rnd_mode = 1'b0;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
